// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// Shares a single sram-like slave between an instruction master and a data
// master. At most one transaction is outstanding. A grant is taken in IDLE,
// the granted master's request is forwarded in ADDR, and DATA waits for the
// slave's completion. Arbitration is round-robin by default. FIXED_PRIO=1
// makes data win every tie.
//
// Ports
//   aclk, aresetn             clock (rising edge); asynchronous active-low reset
//   inst_* (req/wr/size/addr/wdata in; rdata/addr_ok/data_ok out)  inst master
//   data_* (same shape)                                            data master
//   s_* (req/wr/size/addr/wdata out; rdata/addr_ok/data_ok in)     shared slave
module sram_like_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  state_e r_state, w_state_nxt;
  logic   r_grant, w_grant_nxt;        // 0 = inst, 1 = data
  logic   r_last_grant, w_last_nxt;
  logic   w_pick;
  logic   w_gnt_req;
  logic   w_addr_ok;
  logic   w_data_ok;

  // Read data is broadcast; each master qualifies it with its own data_ok.
  assign inst_rdata = s_rdata;
  assign data_rdata = s_rdata;

  assign w_gnt_req = r_grant ? data_req : inst_req;

  // Tie-break: round-robin prefers whoever did not win last time. last_grant
  // resets to inst, so the first contested arbitration goes to data.
  always_comb begin
    w_pick = data_req;
    if (inst_req && data_req) begin
      w_pick = (FIXED_PRIO != 0) ? 1'b1 : ~r_last_grant;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    w_addr_ok   = 1'b0;
    w_data_ok   = 1'b0;
    s_req       = 1'b0;
    s_wr        = 1'b0;
    s_size      = 2'b00;
    s_addr      = 32'h0;
    s_wdata     = 32'h0;

    unique case (r_state)
      StIdle: begin
        if (inst_req || data_req) begin
          w_state_nxt = StAddr;
          w_grant_nxt = w_pick;
          w_last_nxt  = w_pick;
        end
      end

      StAddr: begin
        s_req   = w_gnt_req;
        s_wr    = r_grant ? data_wr    : inst_wr;
        s_size  = r_grant ? data_size  : inst_size;
        s_addr  = r_grant ? data_addr  : inst_addr;
        s_wdata = r_grant ? data_wdata : inst_wdata;
        if (!w_gnt_req) begin
          // Master withdrew its request: abandon without acknowledging.
          w_state_nxt = StIdle;
        end else if (s_addr_ok) begin
          w_addr_ok = 1'b1;
          if (s_data_ok) begin
            w_data_ok   = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_state_nxt = StData;
          end
        end
      end

      StData: begin
        if (s_data_ok) begin
          w_data_ok   = 1'b1;
          w_state_nxt = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign inst_addr_ok = w_addr_ok & ~r_grant;
  assign data_addr_ok = w_addr_ok &  r_grant;
  assign inst_data_ok = w_data_ok & ~r_grant;
  assign data_data_ok = w_data_ok &  r_grant;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= StIdle;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter. Two instances (round-robin and fixed
// priority) share all inputs. A transaction-level model predicts every output
// each cycle, and directed sequences pin the model with literal values.
module tb_sram_like_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] s_rdata;
  logic        s_addr_ok, s_data_ok;

  logic [31:0] inst_rdata_0, data_rdata_0, inst_rdata_1, data_rdata_1;
  logic        inst_addr_ok_0, inst_data_ok_0, data_addr_ok_0, data_data_ok_0;
  logic        inst_addr_ok_1, inst_data_ok_1, data_addr_ok_1, data_data_ok_1;
  logic        s_req_0, s_wr_0, s_req_1, s_wr_1;
  logic [1:0]  s_size_0, s_size_1;
  logic [31:0] s_addr_0, s_wdata_0, s_addr_1, s_wdata_1;

  always #5 aclk = ~aclk;

  sram_like_arbiter #(.FIXED_PRIO(0)) u_rr (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata_0),
    .inst_addr_ok(inst_addr_ok_0), .inst_data_ok(inst_data_ok_0),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata_0),
    .data_addr_ok(data_addr_ok_0), .data_data_ok(data_data_ok_0),
    .s_req(s_req_0), .s_wr(s_wr_0), .s_size(s_size_0), .s_addr(s_addr_0),
    .s_wdata(s_wdata_0), .s_rdata(s_rdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok)
  );

  sram_like_arbiter #(.FIXED_PRIO(1)) u_fp (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata_1),
    .inst_addr_ok(inst_addr_ok_1), .inst_data_ok(inst_data_ok_1),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata_1),
    .data_addr_ok(data_addr_ok_1), .data_data_ok(data_data_ok_1),
    .s_req(s_req_1), .s_wr(s_wr_1), .s_size(s_size_1), .s_addr(s_addr_1),
    .s_wdata(s_wdata_1), .s_rdata(s_rdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok)
  );

  typedef struct packed {
    logic        sreq;
    logic        swr;
    logic [1:0]  ssize;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic        iaok;
    logic        daok;
    logic        idok;
    logic        ddok;
  } out_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Model: who owns the slave (-1 none, 0 inst, 1 data), whether its address
  // has been accepted, and who won the last arbitration.
  int   mo_owner [2] = '{-1, -1};
  logic mo_acc   [2] = '{1'b0, 1'b0};
  logic mo_last  [2] = '{1'b0, 1'b0};

  function automatic logic pick_fn(int m);
    if (inst_req && data_req) return (m == 1) ? 1'b1 : ~mo_last[m];
    return data_req;
  endfunction

  function automatic logic greq_fn(int m);
    return (mo_owner[m] == 1) ? data_req : inst_req;
  endfunction

  function automatic out_t model_out(int m);
    out_t e = '0;
    logic own_data;
    if (!aresetn || mo_owner[m] < 0) return e;
    own_data = (mo_owner[m] == 1);
    if (!mo_acc[m]) begin
      e.sreq   = greq_fn(m);
      e.swr    = own_data ? data_wr    : inst_wr;
      e.ssize  = own_data ? data_size  : inst_size;
      e.saddr  = own_data ? data_addr  : inst_addr;
      e.swdata = own_data ? data_wdata : inst_wdata;
      if (greq_fn(m) && s_addr_ok) begin
        if (own_data) e.daok = 1'b1; else e.iaok = 1'b1;
        if (s_data_ok) begin
          if (own_data) e.ddok = 1'b1; else e.idok = 1'b1;
        end
      end
    end else if (s_data_ok) begin
      if (own_data) e.ddok = 1'b1; else e.idok = 1'b1;
    end
    return e;
  endfunction

  function automatic out_t act_fn(int m);
    if (m == 0)
      return {s_req_0, s_wr_0, s_size_0, s_addr_0, s_wdata_0,
              inst_addr_ok_0, data_addr_ok_0, inst_data_ok_0, data_data_ok_0};
    return {s_req_1, s_wr_1, s_size_1, s_addr_1, s_wdata_1,
            inst_addr_ok_1, data_addr_ok_1, inst_data_ok_1, data_data_ok_1};
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int m = 0; m < 2; m++) begin
        mo_owner[m] <= -1;
        mo_acc[m]   <= 1'b0;
        mo_last[m]  <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (mo_owner[m] < 0) begin
          if (inst_req || data_req) begin
            mo_owner[m] <= pick_fn(m) ? 1 : 0;
            mo_last[m]  <= pick_fn(m);
            mo_acc[m]   <= 1'b0;
          end
        end else if (!mo_acc[m]) begin
          if (!greq_fn(m)) begin
            mo_owner[m] <= -1;
          end else if (s_addr_ok) begin
            if (s_data_ok) mo_owner[m] <= -1;
            else           mo_acc[m]   <= 1'b1;
          end
        end else if (s_data_ok) begin
          mo_owner[m] <= -1;
          mo_acc[m]   <= 1'b0;
        end
      end
    end
  end

  // Pulse counters and grant log, used by the directed checks.
  int cnt_iaok [2] = '{0, 0};
  int cnt_idok [2] = '{0, 0};
  int cnt_daok [2] = '{0, 0};
  int cnt_ddok [2] = '{0, 0};
  bit log0 [$];
  bit log1 [$];

  // Compare process: checks every output of both instances each cycle.
  always @(negedge aclk) begin
    chk("cyc_rr", 72'(act_fn(0)), 72'(model_out(0)));
    chk("cyc_fp", 72'(act_fn(1)), 72'(model_out(1)));
    chk("rdata", {8'h0, inst_rdata_0, data_rdata_0}, {8'h0, s_rdata, s_rdata});
    chk("rdata_fp", {8'h0, inst_rdata_1, data_rdata_1}, {8'h0, s_rdata, s_rdata});
    if (inst_addr_ok_0) cnt_iaok[0] <= cnt_iaok[0] + 1;
    if (inst_data_ok_0) cnt_idok[0] <= cnt_idok[0] + 1;
    if (data_addr_ok_0) cnt_daok[0] <= cnt_daok[0] + 1;
    if (data_data_ok_0) cnt_ddok[0] <= cnt_ddok[0] + 1;
    if (inst_addr_ok_1) cnt_iaok[1] <= cnt_iaok[1] + 1;
    if (inst_data_ok_1) cnt_idok[1] <= cnt_idok[1] + 1;
    if (data_addr_ok_1) cnt_daok[1] <= cnt_daok[1] + 1;
    if (data_data_ok_1) cnt_ddok[1] <= cnt_ddok[1] + 1;
    if (inst_addr_ok_0 || data_addr_ok_0) log0.push_back(data_addr_ok_0);
    if (inst_addr_ok_1 || data_addr_ok_1) log1.push_back(data_addr_ok_1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'h0;
    inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0;
    data_wdata = 32'h0;
    s_rdata = 32'h0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
  endtask

  task automatic rand_inputs();
    inst_req   = ($urandom_range(0, 3) != 0);
    inst_wr    = 1'($urandom_range(0, 1));
    inst_size  = 2'($urandom_range(0, 3));
    inst_addr  = $urandom;
    inst_wdata = $urandom;
    data_req   = ($urandom_range(0, 3) != 0);
    data_wr    = 1'($urandom_range(0, 1));
    data_size  = 2'($urandom_range(0, 3));
    data_addr  = $urandom;
    data_wdata = $urandom;
    s_rdata    = $urandom;
    s_addr_ok  = ($urandom_range(0, 1) != 0);
    s_data_ok  = ($urandom_range(0, 2) == 0);
    aresetn    = ($urandom_range(0, 149) != 0);
  endtask

  int   b_iaok [2];
  int   b_idok [2];
  int   b_daok [2];
  int   b_ddok [2];
  out_t exp_wr;

  initial begin
    clear_inputs();
    aresetn = 1'b0;
    repeat (3) tick();
    #3;
    chk("reset_rr", 72'(act_fn(0)), 72'h0);
    chk("reset_fp", 72'(act_fn(1)), 72'h0);
    aresetn = 1'b1;
    tick();
    log0.delete();
    log1.delete();

    // Both masters held requesting; zero-wait slave.
    inst_req = 1'b1; data_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    repeat (8) tick();
    chk("rr_len", 72'(log0.size()), 72'd4);
    chk("rr_order", 72'({log0[0], log0[1], log0[2], log0[3]}), 72'b1010);
    chk("fp_len", 72'(log1.size()), 72'd4);
    chk("fp_order", 72'({log1[0], log1[1], log1[2], log1[3]}), 72'b1111);
    data_req = 1'b0;
    repeat (2) tick();
    chk("rr_len5", 72'(log0.size()), 72'd5);
    chk("fp_len5", 72'(log1.size()), 72'd5);
    chk("rr_inst_after", 72'(log0[4]), 72'd0);
    chk("fp_inst_after", 72'(log1[4]), 72'd0);
    clear_inputs();
    repeat (2) tick();

    // Inst-only read with a slow slave.
    for (int m = 0; m < 2; m++) begin
      b_iaok[m] = cnt_iaok[m]; b_idok[m] = cnt_idok[m];
      b_daok[m] = cnt_daok[m]; b_ddok[m] = cnt_ddok[m];
    end
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC0_0000;
    repeat (3) tick();
    s_addr_ok = 1'b1;
    #3;
    chk("rd_addr_ok", 72'({inst_addr_ok_0, inst_addr_ok_1}), 72'b11);
    chk("rd_s_addr", 72'(s_addr_0), 72'hBFC0_0000);
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b0;
    #3;
    chk("rd_data_sreq", 72'({s_req_0, s_req_1}), 72'b00);
    repeat (2) tick();
    s_data_ok = 1'b1; s_rdata = 32'h1234_5678;
    #3;
    chk("rd_data_ok", 72'({inst_data_ok_0, inst_data_ok_1}), 72'b11);
    chk("rd_rdata", 72'(inst_rdata_0), 72'h1234_5678);
    tick();
    s_data_ok = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("rd_pulses",
          72'({8'(cnt_iaok[m] - b_iaok[m]), 8'(cnt_idok[m] - b_idok[m]),
               8'(cnt_daok[m] - b_daok[m]), 8'(cnt_ddok[m] - b_ddok[m])}),
          72'h01010000);
    end

    // Data write with same-cycle addr_ok and data_ok.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
    tick();
    s_addr_ok = 1'b1; s_data_ok = 1'b1;
    #3;
    exp_wr = '0;
    exp_wr.sreq = 1'b1; exp_wr.swr = 1'b1; exp_wr.ssize = 2'd2;
    exp_wr.saddr = 32'h8000_1000; exp_wr.swdata = 32'hDEAD_BEEF;
    exp_wr.daok = 1'b1; exp_wr.ddok = 1'b1;
    chk("wr_rr", 72'(act_fn(0)), 72'(exp_wr));
    chk("wr_fp", 72'(act_fn(1)), 72'(exp_wr));
    tick();
    data_req = 1'b0; data_wr = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    #3;
    chk("wr_idle", 72'({s_req_0, s_addr_0, s_req_1, s_addr_1}), 72'h0);
    clear_inputs();
    tick();

    // Reset during DATA, then a late s_data_ok.
    inst_req = 1'b1;
    tick();
    s_addr_ok = 1'b1;
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b0;
    #1;
    aresetn = 1'b0;
    #2;
    chk("rst_data_rr", 72'(act_fn(0)), 72'h0);
    chk("rst_data_fp", 72'(act_fn(1)), 72'h0);
    tick();
    aresetn = 1'b1;
    tick();
    s_data_ok = 1'b1;
    #3;
    chk("rst_late_rr", 72'(act_fn(0)), 72'h0);
    chk("rst_late_fp", 72'(act_fn(1)), 72'h0);
    tick();
    s_data_ok = 1'b0; inst_req = 1'b1;
    tick();
    #3;
    chk("rst_idle_reach", 72'({s_req_0, s_req_1}), 72'b11);
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b1;
    #3;
    chk("withdraw_aok", 72'({inst_addr_ok_0, inst_addr_ok_1, s_req_0, s_req_1}), 72'h0);
    tick();
    clear_inputs();
    tick();

    // Spurious s_data_ok while idle.
    s_data_ok = 1'b1; s_rdata = 32'hCAFE_F00D;
    #3;
    chk("spur_rr", 72'(act_fn(0)), 72'h0);
    chk("spur_fp", 72'(act_fn(1)), 72'h0);
    chk("spur_rdata", 72'(data_rdata_1), 72'hCAFE_F00D);
    tick();
    s_data_ok = 1'b0;
    tick();
    #3;
    chk("spur_after_rr", 72'(act_fn(0)), 72'h0);
    chk("spur_after_fp", 72'(act_fn(1)), 72'h0);

    // Randomized traffic, checked against the model every cycle.
    repeat (3000) begin
      tick();
      rand_inputs();
    end
    tick();
    aresetn = 1'b1;
    clear_inputs();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
